// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit format and arbiter types shared by FIFO, arbiter and link logic
package noc_pkg;

  localparam int FLIT_SIZE = 86;
  localparam int SOP_BIT   = FLIT_SIZE - 1;
  localparam int EOP_BIT   = FLIT_SIZE - 2;
  localparam int NUM_IN    = 4;
  localparam int CREDITS   = 4;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_e;

endpackage

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - combinational round-robin pick: first request above ptr, wrapping
module noc_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = ptr;
    found = 1'b0;
    j     = 0;
    // ptr itself is scanned last so the previous winner has lowest priority
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/noc_out_arbiter.sv
// rtl/noc_out_arbiter.sv - NoC output port: packet-locked round-robin pop, credit flow control, link register
module noc_out_arbiter #(
  parameter  int FLIT_SIZE = noc_pkg::FLIT_SIZE,
  parameter  int NUM_IN    = noc_pkg::NUM_IN,
  parameter  int CREDITS   = noc_pkg::CREDITS,
  parameter  int SOP_BIT   = FLIT_SIZE - 1,
  parameter  int EOP_BIT   = FLIT_SIZE - 2,
  localparam int GW        = $clog2(NUM_IN),
  localparam int CW        = $clog2(CREDITS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_IN-1:0]           empty_i,
  input  logic [NUM_IN*FLIT_SIZE-1:0] data_i,
  output logic [NUM_IN-1:0]           rdreq_o,
  output logic                        out_valid_o,
  output logic [FLIT_SIZE-1:0]        out_data_o,
  input  logic                        credit_i,
  output logic [GW-1:0]               grant_o,
  output logic                        locked_o,
  output logic                        err_o
);

  import noc_pkg::*;

  arb_state_e      state_q;
  logic [GW-1:0]   grant_q;
  logic [CW-1:0]   credit_q;
  logic            hold_q;

  logic [NUM_IN-1:0]    arb_gnt;
  logic [GW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 locked;
  logic [GW-1:0]        sel;
  logic                 sel_req;
  logic                 send;
  logic [FLIT_SIZE-1:0] sel_flit;
  logic                 sop;
  logic                 eop;

  noc_rr_arbiter #(.N(NUM_IN)) u_rr (
    .req     (~empty_i),
    .ptr     (grant_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    locked   = (state_q == ST_LOCKED);
    sel      = locked ? grant_q : arb_idx;
    sel_req  = locked ? !empty_i[grant_q] : arb_any;
    // hold_q keeps the link quiet for the first cycle after reset release
    send     = sel_req && (credit_q != '0) && !hold_q;
    sel_flit = data_i[int'(sel)*FLIT_SIZE +: FLIT_SIZE];
    sop      = sel_flit[SOP_BIT];
    eop      = sel_flit[EOP_BIT];
    rdreq_o  = '0;
    if (send) rdreq_o = locked ? (NUM_IN'(1) << grant_q) : arb_gnt;
    locked_o = locked || (send && sop && !eop);
  end

  assign grant_o = grant_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= GW'(NUM_IN - 1);
      credit_q    <= CW'(CREDITS);
      hold_q      <= 1'b1;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      hold_q      <= 1'b0;
      out_valid_o <= send;
      if (send) begin
        out_data_o <= sel_flit;
        grant_q    <= sel;
      end
      case (state_q)
        ST_IDLE:   if (send && sop && !eop) state_q <= ST_LOCKED;
        ST_LOCKED: if (send && eop)         state_q <= ST_IDLE;
        default:                            state_q <= ST_IDLE;
      endcase
      if (send && !credit_i) begin
        credit_q <= credit_q - CW'(1);
      end else if (!send && credit_i) begin
        if (credit_q == CW'(CREDITS)) err_o    <= 1'b1;
        else                          credit_q <= credit_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_noc_out_arbiter.sv
// tb/tb_noc_out_arbiter.sv - directed bench for noc_out_arbiter with FIFO model and output scoreboard
module tb_noc_out_arbiter;
  import noc_pkg::*;

  localparam int NI = 4;
  localparam int FS = FLIT_SIZE;
  typedef logic [FS-1:0] flit_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI-1:0]    empty_i;
  logic [NI*FS-1:0] data_i;
  logic [NI-1:0]    rdreq_o;
  logic             out_valid_o;
  logic [FS-1:0]    out_data_o;
  logic             credit_i;
  logic [1:0]       grant_o;
  logic             locked_o;
  logic             err_o;

  noc_out_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .empty_i     (empty_i),
    .data_i      (data_i),
    .rdreq_o     (rdreq_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .credit_i    (credit_i),
    .grant_o     (grant_o),
    .locked_o    (locked_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  flit_t         fq [NI][$];
  flit_t         sb [$];
  int            n_assert = 0;
  int            n_fail   = 0;
  logic [NI-1:0] rq;
  logic          lk;
  logic          exp_vld;

  function automatic flit_t mk(input logic s, input logic e, input int id);
    flit_t f;
    f = '0;
    f[SOP_BIT] = s;
    f[EOP_BIT] = e;
    f[31:0] = id;
    return f;
  endfunction

  task automatic chk(input string tag, input flit_t obs, input flit_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int n = 0; n < NI; n++) begin
      empty_i[n] = (fq[n].size() == 0);
      data_i[n*FS +: FS] = (fq[n].size() == 0) ? '0 : fq[n][0];
    end
  endtask

  task automatic load(input int n, input flit_t f, input logic push);
    fq[n].push_back(f);
    if (push) sb.push_back(f);
    refresh();
  endtask

  // one clock: sample at negedge, advance FIFO model after the posedge
  task automatic tick(input logic cr);
    credit_i = cr;
    @(negedge clk);
    rq = rdreq_o;
    lk = locked_o;
    chk("out_valid", flit_t'(out_valid_o), flit_t'(exp_vld));
    if (out_valid_o) begin
      chk("sb_has_entry", flit_t'(sb.size() != 0), flit_t'(1));
      if (sb.size() != 0) chk("out_data", out_data_o, sb.pop_front());
    end
    @(posedge clk);
    #1;
    exp_vld = (|rq) && !rst;
    credit_i = 1'b0;
    for (int n = 0; n < NI; n++)
      if (rq[n] && fq[n].size() != 0) void'(fq[n].pop_front());
    refresh();
  endtask

  task automatic step(input logic cr, input logic [NI-1:0] exp_rq, input string tag);
    tick(cr);
    chk(tag, flit_t'(rq), flit_t'(exp_rq));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdreq"}, flit_t'(rdreq_o), flit_t'(0));
    chk({tag, "_valid"}, flit_t'(out_valid_o), flit_t'(0));
    chk({tag, "_data"}, out_data_o, flit_t'(0));
    chk({tag, "_grant"}, flit_t'(grant_o), flit_t'(NI - 1));
    chk({tag, "_locked"}, flit_t'(locked_o), flit_t'(0));
    chk({tag, "_err"}, flit_t'(err_o), flit_t'(0));
    chk({tag, "_credit"}, flit_t'(dut.credit_q), flit_t'(CREDITS));
  endtask

  initial begin
    rst = 1'b1;
    credit_i = 1'b0;
    exp_vld = 1'b0;
    refresh();
    tick(1'b0);
    // test 1 flits loaded while reset is held: nothing may pop
    load(0, mk(1'b1, 1'b1, 'h10), 1'b1);
    load(2, mk(1'b1, 1'b1, 'h12), 1'b1);
    step(1'b0, 4'b0000, "rst_no_pop");
    chk_reset_state("rst");
    rst = 1'b0;
    step(1'b0, 4'b0000, "release_quiet");

    // single-flit packets on inputs 0 and 2
    step(1'b0, 4'b0001, "t1_pop0");
    step(1'b0, 4'b0100, "t1_pop2");
    step(1'b0, 4'b0000, "t1_idle");
    chk("t1_credit", flit_t'(dut.credit_q), flit_t'(2));
    chk("t1_grant", flit_t'(grant_o), flit_t'(2));
    step(1'b1, 4'b0000, "t1_ret_a");
    step(1'b1, 4'b0000, "t1_ret_b");
    load(0, mk(1'b1, 1'b1, 'h20), 1'b1);
    step(1'b0, 4'b0001, "filler_pop0");
    step(1'b1, 4'b0000, "filler_ret");

    // packet lock: 3-flit packet on input 1 beats waiting input 3
    load(1, mk(1'b1, 1'b0, 'h31), 1'b1);
    load(1, mk(1'b0, 1'b0, 'h32), 1'b1);
    load(1, mk(1'b0, 1'b1, 'h33), 1'b1);
    load(3, mk(1'b1, 1'b1, 'h43), 1'b1);
    step(1'b0, 4'b0010, "t2_sop");
    chk("t2_lock0", flit_t'(lk), flit_t'(1));
    step(1'b0, 4'b0010, "t2_mid");
    chk("t2_lock1", flit_t'(lk), flit_t'(1));
    step(1'b0, 4'b0010, "t2_eop");
    chk("t2_lock2", flit_t'(lk), flit_t'(1));
    step(1'b0, 4'b1000, "t2_in3");
    chk("t2_unlock", flit_t'(lk), flit_t'(0));
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, "t2_ret");
    chk("t2_credit", flit_t'(dut.credit_q), flit_t'(4));

    // credit starvation
    for (int i = 0; i < 6; i++) load(0, mk(1'b1, 1'b1, 'h50 + i), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, "t3_burst");
    step(1'b0, 4'b0000, "t3_stall_a");
    step(1'b0, 4'b0000, "t3_stall_b");
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'b0000, "t3_credit_cycle");
      step(1'b0, 4'b0001, "t3_one_pop");
      step(1'b0, 4'b0000, "t3_after_pop");
    end

    // simultaneous send and credit return at count 1
    step(1'b1, 4'b0000, "t4_give");
    load(0, mk(1'b1, 1'b1, 'h60), 1'b1);
    load(0, mk(1'b1, 1'b1, 'h61), 1'b1);
    step(1'b1, 4'b0001, "t4_both");
    chk("t4_credit_hold", flit_t'(dut.credit_q), flit_t'(1));
    step(1'b0, 4'b0001, "t4_again");
    chk("t4_credit_zero", flit_t'(dut.credit_q), flit_t'(0));
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, "t4_ret");

    // credit overflow
    chk("t5_err_before", flit_t'(err_o), flit_t'(0));
    step(1'b1, 4'b0000, "t5_ovf");
    chk("t5_err_set", flit_t'(err_o), flit_t'(1));
    chk("t5_credit", flit_t'(dut.credit_q), flit_t'(4));
    step(1'b0, 4'b0000, "t5_idle_a");
    step(1'b0, 4'b0000, "t5_idle_b");
    chk("t5_err_sticky", flit_t'(err_o), flit_t'(1));

    // reset after the 2nd flit of a 4-flit packet
    load(2, mk(1'b1, 1'b0, 'h71), 1'b1);
    load(2, mk(1'b0, 1'b0, 'h72), 1'b0);
    load(2, mk(1'b0, 1'b0, 'h73), 1'b0);
    load(2, mk(1'b0, 1'b1, 'h74), 1'b0);
    step(1'b0, 4'b0100, "t6_f1");
    chk("t6_lock_f1", flit_t'(lk), flit_t'(1));
    step(1'b0, 4'b0100, "t6_f2");
    rst = 1'b1;
    exp_vld = 1'b0;
    step(1'b0, 4'b0000, "t6_in_rst");
    chk_reset_state("t6");
    load(0, mk(1'b1, 1'b1, 'h80), 1'b1);
    sb.push_back(mk(1'b0, 1'b0, 'h73));
    sb.push_back(mk(1'b0, 1'b1, 'h74));
    rst = 1'b0;
    step(1'b0, 4'b0000, "t6_release_quiet");
    step(1'b0, 4'b0001, "t6_restart_in0");
    step(1'b0, 4'b0100, "t6_left_a");
    step(1'b0, 4'b0100, "t6_left_b");
    step(1'b0, 4'b0000, "t6_drain_a");
    step(1'b0, 4'b0000, "t6_drain_b");
    chk("sb_drained", flit_t'(sb.size()), flit_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_out_arbiter.md
# noc_out_arbiter

Output-port stage of the NoC router, directly downstream of the per-input flit FIFOs. Each cycle it selects one non-empty input FIFO round-robin, pops its head flit, and registers it onto the outgoing link. It holds the grant for the whole packet, from SOP flit to EOP flit, so packets never interleave. Link flow control is credit-based: one credit per free flit slot in the next router's input FIFO.

## Interface
- FLIT_SIZE, 86: flit width (6+12+68), identical to FIFO data width
- NUM_IN, 4: number of input FIFOs arbitrated
- CREDITS, 4: downstream FIFO depth; credit counter reset value
- SOP_BIT, FLIT_SIZE-1: flit bit marking start of packet
- EOP_BIT, FLIT_SIZE-2: flit bit marking end of packet
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- empty_i  in  NUM_IN  per-input FIFO empty flag (registered at FIFO)
- data_i  in  NUM_IN*FLIT_SIZE  FIFO head flits; input n at [n*FLIT_SIZE +: FLIT_SIZE]
- rdreq_o  out  NUM_IN  one-hot pop strobe to the granted FIFO
- out_valid_o  out  1  registered flit-valid on link
- out_data_o  out  FLIT_SIZE  registered flit on link
- credit_i  in  1  one-cycle pulse: downstream freed one slot
- grant_o  out  clog2(NUM_IN)  currently granted / last granted input
- locked_o  out  1  packet in progress (grant held)
- err_o  out  1  sticky credit-overflow error

## Operation
- Reset values: rdreq_o=0, out_valid_o=0, out_data_o=0, grant_o=NUM_IN-1, locked_o=0, err_o=0, credit count=CREDITS, state IDLE.
- Send condition: credit count > 0 and a selected input is non-empty. Only then does the pop happen.
- IDLE: the candidate is the first non-empty input scanning from grant_o+1 upward, modulo NUM_IN.
  - On send: rdreq_o[cand]=1, grant_o<=cand, flit captured.
  - If the flit has SOP=1 and EOP=0, go to LOCKED. Otherwise stay IDLE.
  - A head flit without SOP is forwarded as a single-flit packet.
- LOCKED: only input grant_o is eligible.
  - Send when empty_i[grant_o]=0 and credit > 0.
  - Popping a flit with EOP=1 returns to IDLE.
  - Other inputs wait regardless of their fill level.
- Output register: on send, out_data_o<=flit and out_valid_o<=1. Otherwise out_valid_o<=0 and out_data_o holds its value.
- Credit counter, width clog2(CREDITS+1):
  - Send only: decrement.
  - credit_i only: increment.
  - Both: unchanged.
  - credit_i at count==CREDITS with no send: count holds, err_o<=1 (sticky until reset).
- rdreq_o is combinational from state, grant_o, empty_i and credit count. It has no combinational path from data_i except through the SOP/EOP bits of the selected flit.

## Timing
- Latency: a flit at the FIFO head in cycle t with credit available is popped in cycle t (rdreq_o=1) and appears at out_valid_o/out_data_o in cycle t+1.
- Throughput: 1 flit/cycle while credits last.
  - CREDITS=4 with no returns: exactly 4 flits sent, then stall.
  - A credit_i in cycle t allows a send in cycle t+1.
- Back-to-back packets from different inputs: no bubble. EOP pop in cycle t, next packet's first flit popped in cycle t+1.
- Reset mid-packet: lock is dropped, credits return to CREDITS, no rdreq_o during or in the cycle after reset deassertion. The upstream FIFO contents are the upstream's concern.

## Structure
- Shared package noc_pkg holds FLIT_SIZE, SOP_BIT and EOP_BIT so the FIFO, the arbiter and the link logic agree on the flit format.
- Sub-module noc_rr_arbiter is combinational. Inputs: request vector (~empty_i) and the pointer (grant_o). Outputs: one-hot grant and encoded index.
- The top level holds the FSM, credit counter, output register and error flag.

## Test plan
- Single-flit packets: inputs 0 and 2 each hold one flit with SOP=EOP=1, credits=4.
  - Required: pops on input 0 then input 2 in consecutive cycles.
  - Required: out_valid_o high for 2 cycles starting one cycle after the first pop; credit count ends at 2.
- Packet lock: input 1 holds a 3-flit packet, input 3 a 1-flit packet, both non-empty at t0.
  - Required: input 1 flits at out cycles t0+1..t0+3, input 3 flit at t0+4, locked_o high during t0..t0+2.
- Credit starvation: 6 single-flit packets queued on input 0, no credit_i.
  - Required: exactly 4 flits out, then rdreq_o=0.
  - A credit_i pulse at cycle t yields exactly one pop at cycle t+1.
- Simultaneous send and credit_i at count 1: count stays 1, and the next cycle sends again.
- Overflow: credit_i with count=CREDITS and idle link. Required: err_o=1 from the next cycle onward and the count stays 4; err_o clears only on rst_i.
- Reset mid-packet: assert rst_i after the 2nd flit of a 4-flit packet.
  - Required: all outputs return to their reset values.
  - Required: after release, arbitration restarts from input 0 and the credit count is 4.
